// File: rtl/data_memory_mmio_pkg.sv
// Shared constants for the data memory: MMIO offsets from the MMIO base,
// TX_STATUS bit positions and the access-region decode.
package data_memory_mmio_pkg;
   localparam logic [1:0] MMIO_CYCLE     = 2'd0;
   localparam logic [1:0] MMIO_LED       = 2'd1;
   localparam logic [1:0] MMIO_TX_DATA   = 2'd2;
   localparam logic [1:0] MMIO_TX_STATUS = 2'd3;

   localparam int COUNT_W       = 5;
   localparam int STAT_COUNT_LO = 0;
   localparam int STAT_COUNT_HI = 4;
   localparam int STAT_FULL     = 8;
   localparam int STAT_EMPTY    = 9;
   localparam int STAT_OVERFLOW = 10;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_CYCLE,
      REG_LED,
      REG_TX_DATA,
      REG_TX_STATUS
   } region_t;

   function automatic region_t decode_region(input logic is_mmio, input logic [1:0] offset);
      region_t r;
      r = REG_RAM;
      if (is_mmio) begin
         case (offset)
            MMIO_CYCLE:   r = REG_CYCLE;
            MMIO_LED:     r = REG_LED;
            MMIO_TX_DATA: r = REG_TX_DATA;
            default:      r = REG_TX_STATUS;
         endcase
      end
      return r;
   endfunction
endpackage

// File: rtl/data_memory_mmio_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the transmit valid/ready consumer.
// Pushes while full and pops while empty are ignored.
module data_memory_mmio_tx_fifo
   import data_memory_mmio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               push,
   input  logic               pop,
   input  logic [7:0]         push_data,
   output logic [7:0]         head_data,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   output logic               empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == COUNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset_n && do_push) mem[wr_ptr] <= push_data;
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + COUNT_W'(do_push) - COUNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/data_memory_mmio.sv
// Word-addressed data memory for the single-cycle core: RAM below the top four
// words, which hold CYCLE, LED, TX_DATA and TX_STATUS. Reads are combinational.
module data_memory_mmio
   import data_memory_mmio_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  dmem_write,
   input  logic [ADDR_WIDTH-1:0] dmem_reg,
   input  logic [31:0]           dmem_write_data,
   output logic [31:0]           dmem_read_data,
   output logic [7:0]            leds,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);
   logic [31:0]        ram [2**ADDR_WIDTH];
   logic [31:0]        cycle;
   logic               overflow;
   logic [31:0]        status;
   region_t            region;
   logic               fifo_push;
   logic               fifo_pop;
   logic [COUNT_W-1:0] fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   assign region    = decode_region(&dmem_reg[ADDR_WIDTH-1:2], dmem_reg[1:0]);
   assign fifo_push = dmem_write && (region == REG_TX_DATA);
   assign fifo_pop  = tx_valid && tx_ready;
   assign tx_valid  = !fifo_empty;

   data_memory_mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (dmem_write_data[7:0]),
      .head_data (tx_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Top four entries are shadowed by MMIO and never written.
   always_ff @(posedge clk) begin
      if (reset_n && dmem_write && region == REG_RAM) ram[dmem_reg] <= dmem_write_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycle    <= '0;
         leds     <= '0;
         overflow <= 1'b0;
      end else begin
         cycle <= cycle + 32'd1;
         if (dmem_write && region == REG_LED) leds <= dmem_write_data[7:0];
         // A push into a full FIFO is lost even if a pop frees a slot this edge.
         if (fifo_push && fifo_full)
            overflow <= 1'b1;
         else if (dmem_write && region == REG_TX_STATUS && dmem_write_data[STAT_OVERFLOW])
            overflow <= 1'b0;
      end
   end

   always_comb begin
      status = '0;
      status[STAT_COUNT_HI:STAT_COUNT_LO] = fifo_count;
      status[STAT_FULL]     = fifo_full;
      status[STAT_EMPTY]    = fifo_empty;
      status[STAT_OVERFLOW] = overflow;
   end

   always_comb begin
      dmem_read_data = '0;
      case (region)
         REG_RAM:       dmem_read_data = ram[dmem_reg];
         REG_CYCLE:     dmem_read_data = cycle;
         REG_LED:       dmem_read_data = {24'b0, leds};
         REG_TX_STATUS: dmem_read_data = status;
         default:       dmem_read_data = '0;
      endcase
   end
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: a queue/array reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_data_memory_mmio;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        dmem_write;
   logic [5:0]  dmem_reg;
   logic [31:0] dmem_write_data;
   logic [31:0] dmem_read_data;
   logic [7:0]  leds;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_vec = 0;
   int n_err = 0;

   data_memory_mmio #(.ADDR_WIDTH(6), .FIFO_DEPTH(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .dmem_write      (dmem_write),
      .dmem_reg        (dmem_reg),
      .dmem_write_data (dmem_write_data),
      .dmem_read_data  (dmem_read_data),
      .leds            (leds),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [31:0] m_ram [64];
   bit          m_ram_known [64];
   logic [31:0] m_cycle;
   logic [7:0]  m_leds;
   logic [7:0]  m_q [$];
   bit          m_ovf;
   bit          m_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 0;
      s = s + m_q.size();
      if (m_q.size() == 8) s = s + 32'h100;
      if (m_q.size() == 0) s = s + 32'h200;
      if (m_ovf)           s = s + 32'h400;
      return s;
   endfunction

   always @(posedge clk) begin
      bit pop;
      bit push_ok;
      if (!reset_n) begin
         m_cycle = 0;
         m_leds  = 0;
         m_q.delete();
         m_ovf   = 0;
         m_on    = 1;
      end else if (m_on) begin
         pop     = (m_q.size() > 0) && tx_ready;
         push_ok = dmem_write && dmem_reg == 62 && m_q.size() < 8;
         if (dmem_write && dmem_reg == 62 && m_q.size() == 8) m_ovf = 1;
         if (dmem_write && dmem_reg == 63 && dmem_write_data[10]) m_ovf = 0;
         if (dmem_write && dmem_reg < 60) begin
            m_ram[dmem_reg]       = dmem_write_data;
            m_ram_known[dmem_reg] = 1;
         end
         if (dmem_write && dmem_reg == 61) m_leds = dmem_write_data[7:0];
         if (pop) void'(m_q.pop_front());
         if (push_ok) m_q.push_back(dmem_write_data[7:0]);
         m_cycle = m_cycle + 1;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("model_leds", {24'b0, leds}, {24'b0, m_leds});
         chk("model_tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) chk("model_tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
         if (dmem_reg < 60) begin
            if (m_ram_known[dmem_reg]) chk("model_ram_read", dmem_read_data, m_ram[dmem_reg]);
         end else if (dmem_reg == 60) chk("model_cycle_read", dmem_read_data, m_cycle);
         else if (dmem_reg == 61)     chk("model_led_read", dmem_read_data, {24'b0, m_leds});
         else if (dmem_reg == 62)     chk("model_txdata_read", dmem_read_data, 32'h0);
         else                         chk("model_status_read", dmem_read_data, m_status());
      end
   end

   task automatic drive(input logic w, input logic [5:0] a, input logic [31:0] d);
      dmem_write      = w;
      dmem_reg        = a;
      dmem_write_data = d;
      @(posedge clk); #1;
   endtask

   task automatic peek(input logic [5:0] a, input logic [31:0] exp, input string name);
      dmem_write      = 0;
      dmem_reg        = a;
      dmem_write_data = 0;
      @(negedge clk);
      chk(name, dmem_read_data, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) m_ram_known[i] = 0;
      reset_n = 0; dmem_write = 0; dmem_reg = 0; dmem_write_data = 0; tx_ready = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;

      repeat (10) drive(0, 6'd0, 0);
      peek(6'd60, 32'd10, "cycle_after_10");
      chk("leds_reset", {24'b0, leds}, 32'h0);
      chk("tx_valid_reset", {31'b0, tx_valid}, 32'h0);
      peek(6'd63, 32'h200, "status_reset");

      drive(1, 6'd5, 32'h11111111);
      dmem_write = 1; dmem_reg = 6'd5; dmem_write_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("ram_read_old", dmem_read_data, 32'h11111111);
      @(posedge clk); #1;
      peek(6'd5, 32'hDEADBEEF, "ram_read_new");
      drive(1, 6'd60, 32'h12345678);

      drive(1, 6'd61, 32'h123);
      chk("leds_write", {24'b0, leds}, 32'h23);
      peek(6'd61, 32'h23, "led_read");

      for (int i = 0; i < 8; i++) drive(1, 6'd62, 32'h41 + i);
      peek(6'd63, 32'h108, "status_full");
      chk("head_0x41", {24'b0, tx_data}, 32'h41);
      drive(1, 6'd62, 32'h49);
      peek(6'd63, 32'h508, "status_overflow");
      drive(1, 6'd63, 32'h400);
      peek(6'd63, 32'h108, "status_ovf_cleared");

      dmem_write = 0; dmem_reg = 6'd63; tx_ready = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("drain_valid", {31'b0, tx_valid}, 32'h1);
         chk("drain_data", {24'b0, tx_data}, 32'h41 + i);
         @(posedge clk); #1;
      end
      chk("drain_done_valid", {31'b0, tx_valid}, 32'h0);
      peek(6'd63, 32'h200, "status_drained");

      tx_ready = 0;
      for (int i = 0; i < 3; i++) drive(1, 6'd62, 32'h50 + i);
      peek(6'd63, 32'h3, "status_count3");
      tx_ready = 1;
      drive(1, 6'd62, 32'h53);
      tx_ready = 0;
      peek(6'd63, 32'h3, "pushpop_count3");
      dmem_reg = 6'd63; tx_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("pushpop_order", {24'b0, tx_data}, 32'h51 + i);
         @(posedge clk); #1;
      end
      tx_ready = 0;

      for (int i = 0; i < 6; i++) drive(1, 6'd62, 32'h60 + i);
      tx_ready = 1;
      drive(0, 6'd63, 0);
      reset_n = 0; dmem_write = 1; dmem_reg = 6'd62; dmem_write_data = 32'h66;
      @(negedge clk);
      chk("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
      @(posedge clk); #1;
      reset_n = 1; dmem_write = 0; dmem_reg = 6'd60; dmem_write_data = 0; tx_ready = 0;
      chk("post_reset_valid", {31'b0, tx_valid}, 32'h0);
      chk("post_reset_leds", {24'b0, leds}, 32'h0);
      @(negedge clk);
      chk("post_reset_cycle", dmem_read_data, 32'h0);
      @(posedge clk); #1;
      peek(6'd63, 32'h200, "post_reset_status");
      peek(6'd5, 32'hDEADBEEF, "ram_survives_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
